// File: rtl/agnus_bitplane_fetch.sv
// Agnus bitplane DMA sequencer: walks each display line in fetch units, claims chip-RAM
// slots for the enabled planes and hands each fetched word to Denise via its BPLxDAT address.
module agnus_bitplane_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        aga,
  input  logic [8:0]  hpos,
  input  logic        bpl_en,
  input  logic [8:1]  reg_address_in,
  input  logic [15:0] data_in,
  output logic        dma_req,
  output logic [2:0]  dma_plane,
  output logic [8:1]  reg_address_out,
  output logic        mod_strobe,
  output logic [1:0]  mod_odd_even
);

  localparam logic [8:1] ADDR_DDFSTRT = 8'h49;
  localparam logic [8:1] ADDR_DDFSTOP = 8'h4A;
  localparam logic [8:1] ADDR_BPLCON0 = 8'h80;
  localparam logic [8:1] ADDR_FMODE   = 8'hFE;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_FETCH = 2'd1;
  localparam logic [1:0] STATE_LAST  = 2'd2;

  localparam logic [1:0] RES_LO = 2'd0;
  localparam logic [1:0] RES_HI = 2'd1;
  localparam logic [1:0] RES_SH = 2'd2;

  logic [7:0] ddfstrt_q, ddfstop_q;
  logic       hires_q, shres_q, bpu3_q;
  logic [2:0] bpu_q;
  logic [1:0] fmode_q;

  logic [1:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] mask_q, mask_d;
  logic [3:0] planes_q, planes_d;
  logic [1:0] res_q, res_d;

  logic       dma_req_q, req_d;
  logic [2:0] dma_plane_q, plane_d;
  logic       final_q, final_d;
  logic [8:1] reg_address_out_q;
  logic       mod_strobe_q;
  logic [1:0] mod_odd_even_q;

  logic [1:0] fmodeEff, liveRes;
  logic [3:0] liveRaw, liveMax, livePlanes;
  logic [4:0] liveMask;
  logic [7:0] curSlot, nextSlot, unitMaskWide;
  logic       slotEdge, slotWrap, startUnit, deliver, modFire;
  logic       unusedDataBits;

  assign unusedDataBits = ^data_in[11:8];

  // Decisions at a slot edge are made for the slot about to begin, which gives zero start latency.
  assign curSlot      = hpos[8:1];
  assign nextSlot     = curSlot + 8'd1;
  assign slotEdge     = hpos[0];
  assign slotWrap     = (curSlot == 8'd0) || (nextSlot == 8'd0);
  assign unitMaskWide = {3'b000, liveMask};
  assign deliver      = slotEdge && dma_req_q;
  assign modFire      = deliver && final_q && bpl_en;

  always_comb begin
    fmodeEff = aga ? fmode_q : 2'd0;
    case (fmodeEff)
      2'd0:    liveMask = 5'd7;
      2'd3:    liveMask = 5'd31;
      default: liveMask = 5'd15;
    endcase
    liveRaw = {aga & bpu3_q, bpu_q};
    if (shres_q) begin
      liveRes = RES_SH;
      liveMax = 4'd2;
    end else if (hires_q) begin
      liveRes = RES_HI;
      liveMax = 4'd4;
    end else begin
      liveRes = RES_LO;
      liveMax = aga ? 4'd8 : 4'd6;
    end
    livePlanes = (liveRaw > liveMax) ? liveMax : liveRaw;
  end

  // Plane-minus-one at each offset of the 8-slot pattern; BPL1 always sits at offset 7.
  function automatic logic [2:0] patternIndex(input logic [1:0] res, input logic [2:0] off);
    logic [2:0] idx;
    idx = 3'd0;
    case (res)
      RES_SH: idx = off[0] ? 3'd0 : 3'd1;
      RES_HI: begin
        case (off[1:0])
          2'd0:    idx = 3'd3;
          2'd1:    idx = 3'd1;
          2'd2:    idx = 3'd2;
          default: idx = 3'd0;
        endcase
      end
      default: begin
        case (off)
          3'd0:    idx = 3'd7;
          3'd1:    idx = 3'd3;
          3'd2:    idx = 3'd5;
          3'd3:    idx = 3'd1;
          3'd4:    idx = 3'd6;
          3'd5:    idx = 3'd2;
          3'd6:    idx = 3'd4;
          default: idx = 3'd0;
        endcase
      end
    endcase
    return idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    planes_d  = planes_q;
    res_d     = res_q;
    startUnit = 1'b0;
    if (!bpl_en || slotWrap) begin
      state_d = STATE_IDLE;
    end else begin
      case (state_q)
        STATE_IDLE:  startUnit = (nextSlot == (ddfstrt_q & ~unitMaskWide)) && (ddfstrt_q <= ddfstop_q);
        STATE_FETCH: if (cnt_q == mask_q) startUnit = 1'b1; else cnt_d = cnt_q + 5'd1;
        STATE_LAST:  if (cnt_q == mask_q) state_d = STATE_IDLE; else cnt_d = cnt_q + 5'd1;
        default:     state_d = STATE_IDLE;
      endcase
    end
    // Mode is sampled only here so mid-unit BPLCON0/FMODE writes wait for the next unit.
    if (startUnit) begin
      cnt_d    = 5'd0;
      mask_d   = liveMask;
      planes_d = livePlanes;
      res_d    = liveRes;
      state_d  = (nextSlot >= (ddfstop_q & ~unitMaskWide)) ? STATE_LAST : STATE_FETCH;
    end
    plane_d = patternIndex(res_d, cnt_d[2:0]);
    req_d   = (state_d != STATE_IDLE) && (cnt_d[4:3] == mask_d[4:3]) && ({1'b0, plane_d} < planes_d);
    final_d = req_d && (state_d == STATE_LAST) && (cnt_d == mask_d);
  end

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        ddfstrt_q         <= 8'd0;
        ddfstop_q         <= 8'd0;
        hires_q           <= 1'b0;
        shres_q           <= 1'b0;
        bpu3_q            <= 1'b0;
        bpu_q             <= 3'd0;
        fmode_q           <= 2'd0;
        state_q           <= STATE_IDLE;
        cnt_q             <= 5'd0;
        mask_q            <= 5'd0;
        planes_q          <= 4'd0;
        res_q             <= RES_LO;
        dma_req_q         <= 1'b0;
        dma_plane_q       <= 3'd0;
        final_q           <= 1'b0;
        reg_address_out_q <= 8'hFF;
        mod_strobe_q      <= 1'b0;
        mod_odd_even_q    <= 2'b00;
      end else begin
        if (reg_address_in == ADDR_DDFSTRT) ddfstrt_q <= data_in[7:0];
        if (reg_address_in == ADDR_DDFSTOP) ddfstop_q <= data_in[7:0];
        if (reg_address_in == ADDR_BPLCON0) begin
          hires_q <= data_in[15];
          bpu_q   <= data_in[14:12];
          shres_q <= data_in[6];
          bpu3_q  <= data_in[4];
        end
        if (reg_address_in == ADDR_FMODE) fmode_q <= data_in[1:0];

        reg_address_out_q <= deliver ? {5'b10001, dma_plane_q} : 8'hFF;
        mod_strobe_q      <= modFire;
        mod_odd_even_q    <= modFire ? {planes_q >= 4'd2, 1'b1} : 2'b00;

        if (slotEdge) begin
          state_q     <= state_d;
          cnt_q       <= cnt_d;
          mask_q      <= mask_d;
          planes_q    <= planes_d;
          res_q       <= res_d;
          dma_req_q   <= req_d;
          dma_plane_q <= req_d ? plane_d : 3'd0;
          final_q     <= final_d;
        end
      end
    end
  end

  assign dma_req         = dma_req_q;
  assign dma_plane       = dma_plane_q;
  assign reg_address_out = reg_address_out_q;
  assign mod_strobe      = mod_strobe_q;
  assign mod_odd_even    = mod_odd_even_q;

endmodule

// File: tb/tb_agnus_bitplane_fetch.sv
// Bench for agnus_bitplane_fetch: a slot-level line model queues the expected request,
// delivery and modulo events, which are popped as the DUT produces them.
module tb_agnus_bitplane_fetch;

  localparam int LINE_TICKS = 454;
  localparam int NONE = -1;
  localparam logic [1:0] EV_REQ = 2'd0;
  localparam logic [1:0] EV_DAT = 2'd1;
  localparam logic [1:0] EV_MOD = 2'd2;

  typedef struct {
    logic [7:0]  strt;
    logic [7:0]  stop;
    logic [15:0] con0;
    logic [1:0]  fmode;
    logic        agaMode;
    int          midTick;
    logic [15:0] midCon0;
    int          dropTick;
    int          resetTick;
  } lineCfg_t;

  logic        clk = 1'b0;
  logic        reset, clk7En, aga, bplEn;
  logic [8:0]  hpos;
  logic [8:1]  regAddrIn;
  logic [15:0] dataIn;
  logic        dmaReq;
  logic [2:0]  dmaPlane;
  logic [8:1]  regAddrOut;
  logic        modStrobe;
  logic [1:0]  modOddEven;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];
  int loresT[8] = '{8, 4, 6, 2, 7, 3, 5, 1};
  int hiresT[8] = '{4, 2, 3, 1, 4, 2, 3, 1};
  int shresT[8] = '{2, 1, 2, 1, 2, 1, 2, 1};

  always #5 clk = ~clk;

  agnus_bitplane_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .clk7_en         (clk7En),
    .aga             (aga),
    .hpos            (hpos),
    .bpl_en          (bplEn),
    .reg_address_in  (regAddrIn),
    .data_in         (dataIn),
    .dma_req         (dmaReq),
    .dma_plane       (dmaPlane),
    .reg_address_out (regAddrOut),
    .mod_strobe      (modStrobe),
    .mod_odd_even    (modOddEven)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] packEvent(input int h, input logic [1:0] kind, input logic [7:0] value);
    return {13'd0, h[8:0], kind, value};
  endfunction

  function automatic void decodeMode(input logic [15:0] con, input logic agaMode, output int n, output int res);
    int raw, maxN;
    raw = int'(con[14:12]) + ((agaMode && con[4]) ? 8 : 0);
    if (con[6]) begin
      res = 2; maxN = 2;
    end else if (con[15]) begin
      res = 1; maxN = 4;
    end else begin
      res = 0; maxN = agaMode ? 8 : 6;
    end
    n = (raw > maxN) ? maxN : raw;
  endfunction

  function automatic lineCfg_t makeCfg(input logic [7:0] strt, input logic [7:0] stop,
                                       input logic [15:0] con0, input logic [1:0] fmode, input logic agaMode);
    lineCfg_t c;
    c.strt = strt; c.stop = stop; c.con0 = con0; c.fmode = fmode; c.agaMode = agaMode;
    c.midTick = NONE; c.midCon0 = 16'h0; c.dropTick = NONE; c.resetTick = NONE;
    return c;
  endfunction

  // Walk the line unit by unit and queue every event the DUT should produce, in hpos order.
  task automatic modelLine(input lineCfg_t c);
    logic [31:0] ev[$];
    int n, res, u, s, slot, plane;
    bit isFinal, stopped;
    logic [15:0] con;
    u = !c.agaMode ? 8 : (c.fmode == 2'd0) ? 8 : (c.fmode == 2'd3) ? 32 : 16;
    if (c.strt <= c.stop) begin
      s = int'(c.strt) & ~(u - 1);
      stopped = 1'b0;
      while (!stopped && s < 256) begin
        con = ((c.midTick != NONE) && (c.midTick < 2 * s - 1)) ? c.midCon0 : c.con0;
        decodeMode(con, c.agaMode, n, res);
        isFinal = (s >= (int'(c.stop) & ~(u - 1)));
        for (int o = 0; o < 8; o++) begin
          slot = s + u - 8 + o;
          plane = (res == 2) ? shresT[o] : (res == 1) ? hiresT[o] : loresT[o];
          if (c.dropTick != NONE && 2 * slot - 1 >= c.dropTick) stopped = 1'b1;
          if (!stopped && plane <= n) begin
            ev.push_back(packEvent(2 * slot, EV_REQ, 8'(plane - 1)));
            ev.push_back(packEvent(2 * slot + 2, EV_DAT, 8'(136 + plane - 1)));
            if (isFinal && o == 7 && (c.dropTick == NONE || 2 * slot + 1 < c.dropTick))
              ev.push_back(packEvent(2 * slot + 2, EV_MOD, {6'd0, n >= 2, 1'b1}));
          end
        end
        if (isFinal) stopped = 1'b1;
        s += u;
      end
    end
    ev.sort();
    foreach (ev[i])
      if (c.resetTick == NONE || int'(ev[i][18:10]) <= c.resetTick) sb.push_back(ev[i]);
  endtask

  task automatic recordEvent(input logic [31:0] obs);
    if (sb.size() == 0) checkOutput("unexpected_event", obs, 32'hFFFFFFFF);
    else checkOutput("event", obs, sb.pop_front());
  endtask

  task automatic observe(input int hh);
    if (hh[0] == 1'b0 && dmaReq !== 1'b0) recordEvent(packEvent(hh, EV_REQ, {5'd0, dmaPlane}));
    if (regAddrOut !== 8'hFF) recordEvent(packEvent(hh, EV_DAT, regAddrOut));
    if (modStrobe !== 1'b0) recordEvent(packEvent(hh, EV_MOD, {6'd0, modOddEven}));
  endtask

  task automatic writeReg(input logic [8:1] addr, input logic [15:0] value);
    regAddrIn = addr;
    dataIn = value;
  endtask

  task automatic applyStimulus(input lineCfg_t c);
    modelLine(c);
    for (int h = 0; h < LINE_TICKS; h++) begin
      @(negedge clk);
      hpos = 9'(h);
      clk7En = 1'b1;
      aga = c.agaMode;
      reset = (h == c.resetTick);
      bplEn = !(c.dropTick != NONE && h >= c.dropTick);
      regAddrIn = 8'hFF;
      dataIn = 16'h0;
      case (h)
        2: writeReg(8'h49, {8'h00, c.strt});
        4: writeReg(8'h4A, {8'h00, c.stop});
        6: writeReg(8'h80, c.con0);
        8: writeReg(8'hFE, {14'd0, c.fmode});
        default: if (h == c.midTick) writeReg(8'h80, c.midCon0);
      endcase
      @(negedge clk);
      clk7En = 1'b0;
      reset = 1'b0;
      observe(h + 1);
      if (h == c.resetTick) begin
        checkOutput("midreset_req", {31'd0, dmaReq}, 32'd0);
        checkOutput("midreset_addr", {24'd0, regAddrOut}, 32'h000000FF);
        checkOutput("midreset_mod", {29'd0, modStrobe, modOddEven}, 32'd0);
      end
    end
    checkOutput("leftover_events", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    lineCfg_t c;
    reset = 1'b1; clk7En = 1'b0; aga = 1'b0; hpos = 9'd0; bplEn = 1'b0;
    regAddrIn = 8'hFF; dataIn = 16'h0;
    @(negedge clk); clk7En = 1'b1;
    @(negedge clk); clk7En = 1'b0; reset = 1'b0;
    checkOutput("reset_req", {31'd0, dmaReq}, 32'd0);
    checkOutput("reset_plane", {29'd0, dmaPlane}, 32'd0);
    checkOutput("reset_addr", {24'd0, regAddrOut}, 32'h000000FF);
    checkOutput("reset_mod", {29'd0, modStrobe, modOddEven}, 32'd0);

    $display("[TB] OCS lores N=4 with FMODE ignored");
    applyStimulus(makeCfg(8'h38, 8'hD0, 16'h4000, 2'd3, 1'b0));
    $display("[TB] hires N=4");
    applyStimulus(makeCfg(8'h38, 8'hD0, 16'hC000, 2'd0, 1'b0));
    $display("[TB] AGA FMODE=3 lores N=8");
    applyStimulus(makeCfg(8'h40, 8'hA0, 16'h0010, 2'd3, 1'b1));
    $display("[TB] AGA FMODE=1 shres N=2");
    applyStimulus(makeCfg(8'h40, 8'h60, 16'h2040, 2'd1, 1'b1));
    $display("[TB] BPLCON0 N=2 to N=5 mid-unit");
    c = makeCfg(8'h38, 8'h50, 16'h2000, 2'd0, 1'b0);
    c.midTick = 'h74; c.midCon0 = 16'h5000;
    applyStimulus(c);
    $display("[TB] OCS lores BPU=7 clamps to 6");
    applyStimulus(makeCfg(8'h38, 8'h48, 16'h7000, 2'd0, 1'b0));
    $display("[TB] hires N=1");
    applyStimulus(makeCfg(8'h38, 8'h40, 16'h9000, 2'd0, 1'b0));
    $display("[TB] bpl_en dropped mid-line");
    c = makeCfg(8'h38, 8'hD0, 16'h4000, 2'd0, 1'b0);
    c.dropTick = 'hB7;
    applyStimulus(c);
    $display("[TB] reset mid-unit");
    c = makeCfg(8'h38, 8'hD0, 16'h4000, 2'd0, 1'b0);
    c.resetTick = 'hB2;
    applyStimulus(c);
    $display("[TB] DDFSTRT beyond DDFSTOP");
    applyStimulus(makeCfg(8'hD0, 8'h38, 16'h4000, 2'd0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
